// File: rtl/fp_pkg.sv
// Shared fp32 types, constants and helpers for the product accumulator.
// Provides field widths, special encodings, the FSM state enum and a leading-zero count.
package fp_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_BIAS  = 127;

    localparam logic [30:0] FP32_QNAN = 31'h7FFFFFFF;
    localparam logic [30:0] FP32_INF  = 31'h7F800000;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } acc_state_e;

    // Leading zeros of a 24-bit value; 24 when the value is zero.
    // Ascending scan so the highest set bit has the final say.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) begin
                n = 5'(23 - i);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp32_adder_rtz.sv
// Combinational fp32 adder, truncating toward zero, with NaN/inf flag propagation.
// Ports: a/a_nan/a_inf, b/b_nan/b_inf operands in; sum/sum_nan/sum_inf result out.
module fp32_adder_rtz
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic        a_nan,
    input  logic        a_inf,
    input  logic [31:0] b,
    input  logic        b_nan,
    input  logic        b_inf,
    output logic [31:0] sum,
    output logic        sum_nan,
    output logic        sum_inf
);

    fp32_t       fa;
    fp32_t       fb;
    fp32_t       big;
    fp32_t       sml;
    logic [30:0] mag_a;
    logic [30:0] mag_b;
    logic [7:0]  diff;
    logic [24:0] m_big;
    logic [24:0] m_sml;
    logic [24:0] m_shf;
    logic [24:0] m_sum;
    logic [4:0]  lz;
    logic [23:0] norm;
    logic [9:0]  r_exp;
    logic [22:0] r_man;
    logic        r_uf;
    logic        r_of;
    logic [31:0] fin;
    logic        fin_inf;
    logic        nan_sign;
    logic        inf_sign;

    always_comb begin
        fa    = a;
        fb    = b;
        // exp==0 (zero or subnormal) contributes nothing
        mag_a = (fa.exp == 8'd0) ? 31'd0 : a[30:0];
        mag_b = (fb.exp == 8'd0) ? 31'd0 : b[30:0];
        if (mag_a >= mag_b) begin
            big = fa;
            sml = fb;
        end else begin
            big = fb;
            sml = fa;
        end

        m_big = (big.exp == 8'd0) ? 25'd0 : {2'b01, big.man};
        m_sml = (sml.exp == 8'd0) ? 25'd0 : {2'b01, sml.man};
        diff  = big.exp - sml.exp;
        m_shf = (diff >= 8'd25) ? 25'd0 : (m_sml >> diff);

        // big magnitude >= shifted small, so the difference never wraps
        if (big.sign ^ sml.sign) begin
            m_sum = m_big - m_shf;
        end else begin
            m_sum = m_big + m_shf;
        end

        lz   = lzc24(m_sum[23:0]);
        norm = m_sum[23:0] << lz;
        if (m_sum[24]) begin
            r_exp = {2'b00, big.exp} + 10'd1;
            r_man = m_sum[23:1];
        end else begin
            r_exp = {2'b00, big.exp} - {5'd0, lz};
            r_man = norm[22:0];
        end

        // r_exp[9] marks a wrapped (negative) exponent
        r_uf = r_exp[9] || (r_exp == 10'd0) || (m_sum == 25'd0);
        r_of = !r_exp[9] && (r_exp >= 10'd255);

        fin_inf = 1'b0;
        if (r_uf) begin
            fin = 32'd0;
        end else if (r_of) begin
            fin     = {big.sign, FP32_INF};
            fin_inf = 1'b1;
        end else begin
            fin = {big.sign, r_exp[7:0], r_man};
        end

        nan_sign = a_nan ? fa.sign : (b_nan ? fb.sign : 1'b0);
        inf_sign = a_inf ? fa.sign : (b_inf ? fb.sign : big.sign);

        sum_nan = a_nan || b_nan ||
                  (a_inf && b_inf && (fa.sign != fb.sign));
        sum_inf = !sum_nan && (a_inf || b_inf || fin_inf);

        if (sum_nan) begin
            sum = {nan_sign, FP32_QNAN};
        end else if (sum_inf) begin
            sum = {inf_sign, FP32_INF};
        end else begin
            sum = fin;
        end
    end

endmodule

// File: rtl/fp32_product_accumulator.sv
// Sums a handshaked stream of fp32 products into one held fp32 result.
// Ports: clk, rstn; in_valid/in_ready/in_data/in_nan/in_inf/in_last; out_valid/out_ready/out_data/out_nan/out_inf/out_count.
module fp32_product_accumulator
    import fp_pkg::*;
#(
    parameter  int MAX_TERMS = 16,
    localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_nan,
    input  logic             in_inf,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_nan,
    output logic             out_inf,
    output logic [CNT_W-1:0] out_count
);

    acc_state_e       state;
    acc_state_e       state_nx;
    logic [31:0]      acc;
    logic             acc_nan;
    logic             acc_inf;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_inc;
    logic             first;
    logic             at_max;
    logic             accept;
    logic [31:0]      add_a;
    logic [31:0]      add_sum;
    logic             add_nan;
    logic             add_inf;

    // A new sum starts from zero rather than clearing acc on the take
    assign first   = (state == IDLE);
    assign cnt_inc = first ? CNT_W'(1) : count + CNT_W'(1);
    assign at_max  = (cnt_inc == CNT_W'(MAX_TERMS));
    assign accept  = in_valid && in_ready;
    assign add_a   = first ? 32'd0 : acc;

    fp32_adder_rtz u_add (
        .a       (add_a),
        .a_nan   (!first && acc_nan),
        .a_inf   (!first && acc_inf),
        .b       (in_data),
        .b_nan   (in_nan),
        .b_inf   (in_inf),
        .sum     (add_sum),
        .sum_nan (add_nan),
        .sum_inf (add_inf)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE, ACCUM: begin
                // low while reset is held even though state reads IDLE
                in_ready = rstn;
                if (in_valid && rstn) begin
                    if (in_last || at_max) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = ACCUM;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc     <= 32'd0;
            acc_nan <= 1'b0;
            acc_inf <= 1'b0;
            count   <= '0;
        end else if (accept) begin
            acc     <= add_sum;
            acc_nan <= add_nan;
            acc_inf <= add_inf;
            count   <= cnt_inc;
        end
    end

    // Partial sums stay internal; outputs read zero until the result is valid
    assign out_data  = out_valid ? acc : 32'd0;
    assign out_nan   = out_valid && acc_nan;
    assign out_inf   = out_valid && acc_inf;
    assign out_count = out_valid ? count : '0;

endmodule

// File: tb/tb_fp32_product_accumulator.sv
// Directed self-checking bench for fp32_product_accumulator.
// Drives on the falling edge, samples on the falling edge after each rising edge.
module tb_fp32_product_accumulator;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_nan;
    logic        out_inf;
    logic [4:0]  out_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp32_product_accumulator #(.MAX_TERMS(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nan   (out_nan),
        .out_inf   (out_inf),
        .out_count (out_count)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [31:0] d,
                       input logic n,
                       input logic f,
                       input logic l);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        in_nan   = n;
        in_inf   = f;
        in_last  = l;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("put_tmo", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_nan   = 1'b0;
        in_inf   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take();
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("take_tmo", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic res(input string tag,
                       input logic [31:0] d,
                       input logic n,
                       input logic f,
                       input logic [4:0] c);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_nan"}, {31'd0, out_nan}, {31'd0, n});
        chk({tag, "_inf"}, {31'd0, out_inf}, {31'd0, f});
        chk({tag, "_cnt"}, {27'd0, out_count}, {27'd0, c});
    endtask

    task automatic zero_outs(input string tag);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_data"}, out_data, 32'd0);
        chk({tag, "_nan"}, {31'd0, out_nan}, 32'd0);
        chk({tag, "_inf"}, {31'd0, out_inf}, 32'd0);
        chk({tag, "_cnt"}, {27'd0, out_count}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        zero_outs("rst");
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_rdy", {31'd0, in_ready}, 32'd1);

        // 1 + 2 + 1.5 = 4.5
        put(32'h3F800000, 0, 0, 0);
        put(32'h40000000, 0, 0, 0);
        put(32'h3FC00000, 0, 0, 1);
        res("t1", 32'h40900000, 0, 0, 5'd3);
        take();
        chk("t1_clr", {31'd0, out_valid}, 32'd0);

        // exact cancellation
        put(32'h40000000, 0, 0, 0);
        put(32'hC0000000, 0, 0, 1);
        res("t2", 32'h00000000, 0, 0, 5'd2);
        take();

        // overflow to +inf
        put(32'h7F7FFFFF, 0, 0, 0);
        put(32'h7F7FFFFF, 0, 0, 1);
        res("t3a", 32'h7F800000, 0, 1, 5'd2);
        take();

        // +inf + -inf
        put(32'h7F800000, 0, 1, 0);
        put(32'hFF800000, 0, 1, 1);
        res("t3b", 32'h7FFFFFFF, 1, 0, 5'd2);
        take();

        // sticky NaN on beat 2
        put(32'h3F800000, 0, 0, 0);
        put(32'h3F800000, 1, 0, 0);
        put(32'h3F800000, 0, 0, 0);
        put(32'h3F800000, 0, 0, 1);
        res("t4", 32'h7FFFFFFF, 1, 0, 5'd4);
        take();

        // 1.0 - 0.5 = 0.5, normalise left
        put(32'h3F800000, 0, 0, 0);
        put(32'hBF000000, 0, 0, 1);
        res("t7", 32'h3F000000, 0, 0, 5'd2);
        take();

        // 2^24 + 1.0 truncates away the 1.0
        put(32'h4B800000, 0, 0, 0);
        put(32'h3F800000, 0, 0, 1);
        res("t8", 32'h4B800000, 0, 0, 5'd2);
        take();

        // subnormal counts as zero
        put(32'h00400000, 0, 0, 0);
        put(32'h3F800000, 0, 0, 1);
        res("t9", 32'h3F800000, 0, 0, 5'd2);
        take();

        // -inf absorbs a finite term, keeps its sign
        put(32'h40000000, 0, 0, 0);
        put(32'hFF800000, 0, 1, 1);
        res("t10", 32'hFF800000, 0, 1, 5'd2);
        take();

        // MAX_TERMS terminates the sum
        for (int i = 0; i < 16; i++) begin
            put(32'h3F800000, 0, 0, 0);
        end
        res("t5", 32'h41800000, 0, 0, 5'd16);
        in_valid = 1'b1;
        in_data  = 32'h40400000;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_vld", {31'd0, out_valid}, 32'd1);
            chk("t5_hold_data", out_data, 32'h41800000);
            chk("t5_hold_cnt", {27'd0, out_count}, 32'd16);
            chk("t5_hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t5_take_vld", {31'd0, out_valid}, 32'd0);
        chk("t5_take_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        res("t5b", 32'h40400000, 0, 0, 5'd1);
        take();

        // reset mid-sum
        put(32'h3F800000, 0, 0, 0);
        put(32'h3F800000, 0, 0, 0);
        rstn = 1'b0;
        #1;
        zero_outs("t6_rst");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        put(32'h40400000, 0, 0, 1);
        res("t6", 32'h40400000, 0, 0, 5'd1);
        take();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
